// File: rtl/taxi_arb.sv
// N-port request arbiter: fixed or round-robin priority, optional grant hold
// (until the request drops or until ack), all outputs registered.

module taxi_arb_penc #(
  parameter int WIDTH         = 4,
  parameter int IW            = 2,
  parameter int LSB_HIGH_PRIO = 0
) (
  input  logic [WIDTH-1:0] in,
  output logic             vld,
  output logic [IW-1:0]    idx
);

  // Scan toward the winning end so the last hit is the highest-priority bit.
  always_comb begin
    vld = |in;
    idx = '0;
    if (LSB_HIGH_PRIO != 0) begin
      for (int i = WIDTH-1; i >= 0; i--)
        if (in[i]) idx = IW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (in[i]) idx = IW'(i);
    end
  end

endmodule

module taxi_arb #(
  parameter int PORTS           = 4,
  parameter int ARB_ROUND_ROBIN = 0,
  parameter int ARB_BLOCK       = 0,
  parameter int ARB_BLOCK_ACK   = 1,
  parameter int LSB_HIGH_PRIO   = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PORTS-1:0]                           req,
  input  logic [PORTS-1:0]                           ack,
  output logic [PORTS-1:0]                           grant,
  output logic                                       grant_valid,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant_index
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] mask, mask_next, masked_req;
  logic [PORTS-1:0] grant_next;
  logic             valid_next;
  logic [IW-1:0]    index_next, win_idx;
  logic             req_vld, msk_vld;
  logic [IW-1:0]    req_idx, msk_idx;
  logic             hold_req, hold_ack;

  assign masked_req = req & mask;

  taxi_arb_penc #(.WIDTH(PORTS), .IW(IW), .LSB_HIGH_PRIO(LSB_HIGH_PRIO)) u_enc_req (
    .in (req),
    .vld(req_vld),
    .idx(req_idx)
  );

  taxi_arb_penc #(.WIDTH(PORTS), .IW(IW), .LSB_HIGH_PRIO(LSB_HIGH_PRIO)) u_enc_msk (
    .in (masked_req),
    .vld(msk_vld),
    .idx(msk_idx)
  );

  assign hold_req = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) && (|(grant & req));
  assign hold_ack = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && grant_valid && !(|(grant & ack));

  always_comb begin
    grant_next = grant;
    valid_next = grant_valid;
    index_next = grant_index;
    mask_next  = mask;
    win_idx    = req_idx;
    if (!(hold_req || hold_ack)) begin
      if (req_vld) begin
        // Masked requests sit after the last winner; fall back to plain priority when none.
        if ((ARB_ROUND_ROBIN != 0) && msk_vld)
          win_idx = msk_idx;
        for (int i = 0; i < PORTS; i++) begin
          grant_next[i] = (win_idx == IW'(i));
          mask_next[i]  = (LSB_HIGH_PRIO != 0) ? (i > int'(win_idx)) : (i < int'(win_idx));
        end
        valid_next = 1'b1;
        index_next = win_idx;
      end else begin
        grant_next = '0;
        valid_next = 1'b0;
        index_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
      mask        <= '0;
    end else begin
      grant       <= grant_next;
      grant_valid <= valid_next;
      grant_index <= index_next;
      mask        <= mask_next;
    end
  end

endmodule

// File: tb/tb_taxi_arb.sv
// Bench for taxi_arb: several parameterisations side by side, scoreboard of
// expected outputs pushed on drive and popped one cycle later.

module tb_taxi_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUTs 0..4 are 4-port, DUT 5 is single-port
  logic [4:0][3:0] req_a, ack_a, grant_a;
  logic [4:0]      gv_a;
  logic [4:0][1:0] gi_a;
  logic            req1, ack1, grant1, gv1;
  logic [0:0]      gi1;

  taxi_arb #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u_arb0 (
    .clk(clk), .rst(rst), .req(req_a[0]), .ack(ack_a[0]),
    .grant(grant_a[0]), .grant_valid(gv_a[0]), .grant_index(gi_a[0]));
  taxi_arb #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u_arb1 (
    .clk(clk), .rst(rst), .req(req_a[1]), .ack(ack_a[1]),
    .grant(grant_a[1]), .grant_valid(gv_a[1]), .grant_index(gi_a[1]));
  taxi_arb #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(0)) u_arb2 (
    .clk(clk), .rst(rst), .req(req_a[2]), .ack(ack_a[2]),
    .grant(grant_a[2]), .grant_valid(gv_a[2]), .grant_index(gi_a[2]));
  taxi_arb #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIO(1)) u_arb3 (
    .clk(clk), .rst(rst), .req(req_a[3]), .ack(ack_a[3]),
    .grant(grant_a[3]), .grant_valid(gv_a[3]), .grant_index(gi_a[3]));
  taxi_arb #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u_arb4 (
    .clk(clk), .rst(rst), .req(req_a[4]), .ack(ack_a[4]),
    .grant(grant_a[4]), .grant_valid(gv_a[4]), .grant_index(gi_a[4]));
  taxi_arb #(.PORTS(1), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u_arb5 (
    .clk(clk), .rst(rst), .req(req1), .ack(ack1),
    .grant(grant1), .grant_valid(gv1), .grant_index(gi1));

  typedef struct {
    int         dut;
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
    string      tag;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] actual(input int d);
    if (d == 5) return {3'b000, grant1, gv1, 1'b0, gi1};
    return {grant_a[d], gv_a[d], gi_a[d]};
  endfunction

  task automatic chk(input string tag, input logic [6:0] act, input logic [3:0] eg,
                     input logic ev, input logic [1:0] ei);
    checks += 3;
    if (act[6:3] !== eg) begin
      errors++;
      $display("FAIL %s grant got %b want %b", tag, act[6:3], eg);
    end
    if (act[2] !== ev) begin
      errors++;
      $display("FAIL %s grant_valid got %b want %b", tag, act[2], ev);
    end
    if (act[1:0] !== ei) begin
      errors++;
      $display("FAIL %s grant_index got %0d want %0d", tag, act[1:0], ei);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected result, compare after the edge.
  task automatic drive(input int d, input logic [3:0] r, input logic [3:0] a,
                       input logic [3:0] eg, input logic ev, input logic [1:0] ei,
                       input string tag, input logic rs = 1'b0);
    exp_t e;
    rst = rs;
    if (d == 5) begin
      req1 = r[0];
      ack1 = a[0];
    end else begin
      req_a[d] = r;
      ack_a[d] = a;
    end
    sb.push_back('{d, eg, ev, ei, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, actual(e.dut), e.g, e.v, e.i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    tbl[1] = '{4'b0011, 4'b0001, 1'b1, 2'd0};
    tbl[2] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1, 2'd3};
    tbl[4] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    tbl[5] = '{4'b1100, 4'b0100, 1'b1, 2'd2};

    // Reset with every request asserted
    rst = 1'b1;
    req_a = '1; ack_a = '0; req1 = 1'b1; ack1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 6; d++) chk($sformatf("reset_dut%0d", d), actual(d), 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    req_a = '0; req1 = 1'b0;
    @(posedge clk);
    #1;

    // Block until ack
    drive(0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "blk_ack_grant");
    for (int k = 0; k < 3; k++) drive(0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, "blk_ack_hold");
    drive(0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, "blk_ack_release");
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "blk_ack_idle");

    // Mid-grant reset must also clear the round-robin mask
    drive(0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, "pre_rst_grant");
    drive(0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, "mid_grant_rst", 1'b1);

    // Round-robin rotation with ack on each grant
    drive(0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, "rr_0");
    drive(0, 4'b1111, 4'b0010, 4'b0001, 1'b1, 2'd0, "rr_wrong_ack");
    drive(0, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1, "rr_1");
    drive(0, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd2, "rr_2");
    drive(0, 4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd3, "rr_3");
    drive(0, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd0, "rr_wrap");
    drive(0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, "rr_hold_noreq");
    drive(0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, "rr_done");

    // Fixed priority, lowest index wins
    drive(1, 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, "fix_lsb_0");
    drive(1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 2'd1, "fix_lsb_1");
    drive(1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 2'd1, "fix_lsb_2");
    drive(1, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, "fix_lsb_done");

    // Fixed priority, highest index wins
    drive(2, 4'b0110, 4'b0000, 4'b0100, 1'b1, 2'd2, "fix_msb");
    drive(2, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, "fix_msb_done");

    // Hold while the granted request stays high
    drive(3, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, "blk_req_grant");
    drive(3, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, "blk_req_hold0");
    drive(3, 4'b1111, 4'b1111, 4'b0010, 1'b1, 2'd1, "blk_req_hold1");
    drive(3, 4'b1101, 4'b0000, 4'b0100, 1'b1, 2'd2, "blk_req_next");
    drive(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "blk_req_idle");

    // Non-blocking, re-arbitrates every cycle
    for (int k = 0; k < 6; k++)
      drive(4, tbl[k].req, 4'b0000, tbl[k].g, tbl[k].v, tbl[k].i, $sformatf("nonblk_%0d", k));

    // Single port
    drive(5, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "p1_grant");
    drive(5, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, "p1_hold");
    drive(5, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, "p1_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_arb.md
Name: taxi_arb

Overview:
- Parameterised N-port request arbiter with registered outputs, used to serialise access to a shared resource (e.g. the slave-side mux of an AXI-lite interconnect).
- Each cycle it selects one requester by fixed or round-robin priority.
- It outputs the result as a one-hot grant, a valid flag and a binary index.
- The grant can be held until the requester drops its request, or until the requester acknowledges completion.

Parameters:
- PORTS, 4, number of requesters (>=1).
- ARB_ROUND_ROBIN, 0, 1 = round-robin priority; 0 = fixed priority.
- ARB_BLOCK, 0, 1 = hold the current grant under the blocking rule below; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 1, when ARB_BLOCK=1: 1 = hold until ack; 0 = hold while the granted request stays asserted.
- LSB_HIGH_PRIO, 0, 1 = lowest index has highest priority; 0 = highest index wins.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  PORTS  request vector, one bit per port.
- ack  in  PORTS  completion acknowledge, one bit per port (used only when ARB_BLOCK_ACK=1).
- grant  out  PORTS  one-hot grant, registered.
- grant_valid  out  1  high when any grant is active, registered.
- grant_index  out  max(1,$clog2(PORTS))  binary index of the granted port, registered.

Behaviour:
- Reset: grant=0, grant_valid=0, grant_index=0, round-robin mask=0.
- Latency: req asserted in cycle N produces grant in cycle N+1. All outputs come straight from flops.
- Priority encoder: finds the winning set bit of a vector, lowest index if LSB_HIGH_PRIO=1, else highest. Also produces a valid flag and the index.
- Next-state evaluation each cycle, first matching rule wins:
  1. Block on request (ARB_BLOCK=1, ARB_BLOCK_ACK=0, (grant & req)!=0): all outputs held.
  2. Block on ack (ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1, (grant & ack)==0): all outputs held, regardless of req.
  3. Fresh arbitration with req!=0:
     - Round-robin, (req & mask)!=0: winner is the encoder result on req & mask.
     - Round-robin, (req & mask)==0: winner is the encoder result on unmasked req.
     - Fixed priority: winner is always the encoder result on unmasked req.
     - Set grant = one-hot(winner), grant_valid=1, grant_index=winner.
  4. req==0 and not held: grant=0, grant_valid=0, grant_index=0.
- Mask update on every fresh grant at index k:
  - LSB_HIGH_PRIO=1: mask = all-ones << (k+1).
  - LSB_HIGH_PRIO=0: mask = all-ones >> (PORTS-k).
  - Effect: ports strictly after k in priority order are favoured next; when none of them request, priority wraps to the unmasked encoder.
- Ack for the granted port releases the hold and re-arbitrates in that same cycle. The new grant appears on the next edge with no idle cycle if other requests are pending.
- Ack for a non-granted port is ignored.
- In ack-blocking mode the grant persists even if req drops.
- PORTS=1: grant_index is a constant 0; grant=1 whenever grant_valid=1.
- Reset mid-grant: outputs and mask return to reset values on the next edge; arbitration restarts from the reset mask (unmasked priority).

Test Plan:
- Reset (PORTS=4, RR=1, BLOCK=1, BLOCK_ACK=1, LSB=1): assert rst 2 cycles with req=1111 -> grant=0000, grant_valid=0, grant_index=0.
- Block until ack (same config): req=0001 for one cycle, then req=0000 -> grant=0001, index=0, valid=1 held indefinitely. Pulse ack=0001 -> next cycle grant=0000, valid=0.
- Round-robin rotation (same config): req=1111 constant, ack pulsed on each granted port -> grant sequence 0001,0010,0100,1000,0001, indices 0,1,2,3,0. Ack=0010 while grant=0001 changes nothing.
- Fixed priority (RR=0, LSB=1): req=1010, ack each grant -> grant stays 0010 every arbitration. LSB=0 with req=0110 -> grant 0100, index 2.
- Request blocking (BLOCK=1, BLOCK_ACK=0): grant=0010 held while req[1]=1 even with req=1111. Drop req[1] -> next grant 0100 (RR).
- Non-blocking (BLOCK=0, RR=0, LSB=1): req 0100 then 0011 then 0000 -> grant 0100, 0001, 0000 on successive cycles, each one cycle after its req.
